// File: rtl/addsub_scheduler.sv
// rtl/addsub_scheduler.sv - round-robin scheduler sharing one 4-bit add/subtract datapath between two requesters

// 4-bit ripple-carry adder; sum[4] is the carry out, so the result is the zero-extended sum.
module bits4_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] sum
);

  logic [4:0] carry;

  // Ripple the carry from bit 0 upward.
  always_comb begin
    carry    = 5'b00000;
    sum      = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    sum[4] = carry[4];
  end

endmodule

// 4-bit ripple-borrow subtractor; diff is the 5-bit two's complement of a-b.
// The final borrow doubles as the sign bit because both operands are unsigned.
module bits4_substrator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] diff
);

  logic [4:0] borrow;

  // Ripple the borrow from bit 0 upward.
  always_comb begin
    borrow = 5'b00000;
    diff   = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      diff[i]       = a[i] ^ b[i] ^ borrow[i];
      borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end
    diff[4] = borrow[4];
  end

endmodule

module addsub_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [5:0] rsp_result,
  output logic       busy,
  output logic [7:0] done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       last_grant;
  logic       grant;
  logic       accept;
  logic       op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       sel_op;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic [4:0] sum;
  logic [4:0] diff;
  logic [5:0] dp_result;

  bits4_adder u_adder (
    .a   (a_q),
    .b   (b_q),
    .sum (sum)
  );

  bits4_substrator u_substrator (
    .a    (a_q),
    .b    (b_q),
    .diff (diff)
  );

  // Next state plus round-robin grant; a grant is only issued from IDLE.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
          if (req0_valid && req1_valid) begin
            grant = ~last_grant;
          end else begin
            grant = req1_valid;
          end
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked by rst so the reset values show up without waiting for a clock.
  assign req0_ready = accept & ~grant & ~rst;
  assign req1_ready = accept &  grant & ~rst;

  assign sel_op = grant ? req1_op : req0_op;
  assign sel_a  = grant ? req1_a  : req0_a;
  assign sel_b  = grant ? req1_b  : req0_b;

  // Subtract sign-extends the 5-bit difference; add zero-extends the 5-bit sum.
  assign dp_result = op_q ? {diff[4], diff} : {1'b0, sum};

  // State register and round-robin history; last_grant starts at 1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant <= grant;
      end
    end
  end

  // Operand capture on accept; the requester is free to move on afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 1'b0;
      a_q  <= 4'h0;
      b_q  <= 4'h0;
    end else if (accept) begin
      op_q <= sel_op;
      a_q  <= sel_a;
      b_q  <= sel_b;
    end
  end

  // Response payload: owner id on accept, datapath result at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= 1'b0;
      rsp_result <= 6'b000000;
    end else begin
      if (accept) begin
        rsp_id <= grant;
      end
      if (state_q == EXEC) begin
        rsp_result <= dp_result;
      end
    end
  end

  // Registered status flags derived from the next state so they track the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RESP);
      busy      <= (state_d != IDLE);
    end
  end

  // Completion counter advances on each response handshake and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count <= 8'h00;
    end else if (state_q == RESP && rsp_ready) begin
      done_count <= done_count + 8'h01;
    end
  end

endmodule
